queue_2x124: RTL and testbench
==============================

Name: queue_2x124

Overview:
- Two-entry, 124-bit-wide ready/valid FIFO controller. Instantiates ram_2x124 as its storage array and owns the enqueue/dequeue pointers, full/empty tracking and occupancy count.
- Sits between a producer pipeline stage and a consumer stage as a decoupling buffer. Drives the RAM write port from the enqueue side and the RAM read port from the dequeue side.

Parameters:
- FLOW, 0, 1 = combinational bypass: when empty, enqueue data is presented directly on dequeue in the same cycle.
- PIPE, 0, 1 = when full, enqueue is accepted in the same cycle as a dequeue.

Ports:
- clock  input  1  single clock; all state and the RAM write port use its rising edge
- reset  input  1  asynchronous, active-high reset
- io_enq_valid  input  1  producer has data
- io_enq_ready  output  1  queue accepts data this cycle
- io_enq_bits  input  124  enqueue payload
- io_deq_valid  output  1  queue presents data
- io_deq_ready  input  1  consumer takes data this cycle
- io_deq_bits  output  124  dequeue payload
- io_flush  input  1  synchronous discard of all stored entries
- io_count  output  2  current occupancy, 0..2

Behaviour:
- State:
  - enq_ptr (1b) and deq_ptr (1b); each increments modulo 2 (toggles) on its fire.
  - maybe_full (1b).
  - ptr_match = (enq_ptr == deq_ptr); empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- Reset: asynchronous, active-high. enq_ptr=0, deq_ptr=0, maybe_full=0. Outputs during and after reset:
  - io_enq_ready=1, io_deq_valid=0, io_count=0.
  - With FLOW=1, io_deq_valid follows io_enq_valid, because the queue is empty.
  - RAM contents are not reset.
- Base handshake, FLOW=0 and PIPE=0:
  - io_enq_ready = ~full; io_deq_valid = ~empty.
  - do_enq = io_enq_valid & io_enq_ready; do_deq = io_deq_valid & io_deq_ready.
- RAM hookup:
  - W0_clk=clock, W0_en=do_enq, W0_addr=enq_ptr, W0_data=io_enq_bits.
  - R0_clk=clock, R0_en=1, R0_addr=deq_ptr, io_deq_bits=R0_data.
  - Read is combinational, so head data is visible in the cycle after the enqueue write.
- Latency: with FLOW=0, minimum enqueue-to-dequeue latency is 1 cycle.
- maybe_full update: on the clock edge, if do_enq != do_deq, maybe_full <= do_enq. Simultaneous enqueue and dequeue leaves it unchanged.
- FLOW=1:
  - If empty: io_deq_valid = io_enq_valid and io_deq_bits = io_enq_bits.
  - If additionally io_deq_ready=1: do_enq=0 and do_deq=0 (no RAM write, no pointer movement). Latency is 0 cycles.
- PIPE=1: io_enq_ready = ~full | io_deq_ready. When full, a simultaneous enqueue and dequeue writes the slot being vacated. The RAM write lands at the edge; the current read is unaffected.
- io_count = {full, enq_ptr ^ deq_ptr}. It is registered-state derived and never exceeds 2.
- io_flush, synchronous, sampled at the rising edge:
  - enq_ptr, deq_ptr and maybe_full are cleared to 0 at the next edge.
  - Flush has priority over do_enq and do_deq: any enqueue in the flush cycle is dropped, with no RAM write enable.
  - io_enq_ready and io_deq_valid in the flush cycle are computed from pre-flush state, so the consumer may still take the head that cycle.
- Boundaries:
  - Enqueue when full (PIPE=0): no write, no state change.
  - Dequeue when empty (FLOW=0): no pointer change.
  - io_deq_bits is don't-care while io_deq_valid=0.
  - Pointer wrap 1->0 is natural 1-bit overflow.
- Reset mid-operation: reset asserted at any time clears state immediately (asynchronous); stored data is abandoned.

Test Plan:
- Reset, then enqueue A=124'h1 and B=124'h2 on consecutive cycles with io_deq_ready=0 -> io_count 1 then 2; io_enq_ready=0 after B; io_deq_bits=124'h1 with io_deq_valid=1.
- From full, hold io_deq_ready=1 for 2 cycles -> outputs 124'h1 then 124'h2; io_count 2->1->0; io_deq_valid=0 afterwards; io_enq_ready=1.
- Streaming: io_enq_valid=io_deq_ready=1 for 10 cycles with incrementing data 0..9 -> dequeue order 0..9 with 1-cycle lag; io_count holds at 1; pointers wrap without loss.
- FLOW=1, empty, enqueue 124'hABC with io_deq_ready=1 -> io_deq_valid=1 and io_deq_bits=124'hABC in the same cycle; io_count stays 0; no RAM write.
- PIPE=1, full (124'h5, 124'h6), enqueue 124'h7 with io_deq_ready=1 -> 124'h5 dequeued, 124'h7 accepted, io_count stays 2; the next two dequeues return 124'h6 then 124'h7.
- With io_count=2, assert io_flush together with io_enq_valid=1 -> io_count=0 at the next cycle, io_deq_valid=0, flushed-cycle enqueue absent. Separately, assert reset mid-stream -> io_count=0 and io_enq_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/queue_2x124.sv
// Two-entry, 124-bit ready/valid FIFO with optional flow-through and pipelining.
// Storage lives in ram_2x124; this block owns the pointers and full/empty tracking.

module ram_2x124 (
    input  logic         R0_addr,
    input  logic         R0_en,
    input  logic         R0_clk,
    output logic [123:0] R0_data,
    input  logic         W0_addr,
    input  logic         W0_en,
    input  logic         W0_clk,
    input  logic [123:0] W0_data
);
    logic [123:0] r_mem [0:1];
    logic         w_unused;

    // The read side is asynchronous, so its clock is not used.
    assign w_unused = R0_clk;

    // Write port: one entry per enabled rising edge; contents are never reset.
    always_ff @(posedge W0_clk) begin
        if (W0_en) r_mem[W0_addr] <= W0_data;
    end

    // Combinational read of the addressed entry.
    assign R0_data = R0_en ? r_mem[R0_addr] : '0;
endmodule

module queue_2x124 #(
    parameter int FLOW = 0,
    parameter int PIPE = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_enq_valid,
    output logic         io_enq_ready,
    input  logic [123:0] io_enq_bits,
    output logic         io_deq_valid,
    input  logic         io_deq_ready,
    output logic [123:0] io_deq_bits,
    input  logic         io_flush,
    output logic [1:0]   io_count
);
    localparam logic LP_FLOW = (FLOW != 0);
    localparam logic LP_PIPE = (PIPE != 0);

    logic         r_enq_ptr;
    logic         r_deq_ptr;
    logic         r_maybe_full;

    logic         w_ptr_match;
    logic         w_empty;
    logic         w_full;
    logic         w_bypass;
    logic         w_do_enq;
    logic         w_do_deq;
    logic         w_wr_en;
    logic [123:0] w_ram_rdata;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match & r_maybe_full;

    // Flow-through: an empty queue hands enqueue data straight to a ready consumer.
    assign w_bypass = LP_FLOW & w_empty & io_deq_ready;

    assign io_enq_ready = ~w_full | (LP_PIPE & io_deq_ready);
    assign io_deq_valid = ~w_empty | (LP_FLOW & io_enq_valid);

    assign w_do_enq = io_enq_valid & io_enq_ready & ~w_bypass;
    assign w_do_deq = io_deq_valid & io_deq_ready & ~w_bypass;

    // A flushed cycle drops the enqueue entirely, including the RAM write.
    assign w_wr_en = w_do_enq & ~io_flush;

    assign io_deq_bits = (LP_FLOW & w_empty) ? io_enq_bits : w_ram_rdata;
    assign io_count    = {w_full, r_enq_ptr ^ r_deq_ptr};

    ram_2x124 u_ram (
        .R0_addr (r_deq_ptr),
        .R0_en   (1'b1),
        .R0_clk  (clock),
        .R0_data (w_ram_rdata),
        .W0_addr (r_enq_ptr),
        .W0_en   (w_wr_en),
        .W0_clk  (clock),
        .W0_data (io_enq_bits)
    );

    // Pointer and full-flag state; flush outranks any enqueue/dequeue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_enq_ptr    <= 1'b0;
            r_deq_ptr    <= 1'b0;
            r_maybe_full <= 1'b0;
        end else if (io_flush) begin
            r_enq_ptr    <= 1'b0;
            r_deq_ptr    <= 1'b0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_do_enq) r_enq_ptr <= ~r_enq_ptr;
            if (w_do_deq) r_deq_ptr <= ~r_deq_ptr;
            if (w_do_enq != w_do_deq) r_maybe_full <= w_do_enq;
        end
    end
endmodule

// File: tb/tb_queue_2x124.sv
// Directed bench for queue_2x124: a vector table for the base queue plus
// hand-written sequences for streaming, flow-through, pipelining and reset.

module tb_queue_2x124;
    logic         clock;
    logic         reset;
    logic         enq_valid;
    logic [123:0] enq_bits;
    logic         deq_ready;
    logic         flush;

    logic         d_er, d_dv, f_er, f_dv, p_er, p_dv;
    logic [123:0] d_db, f_db, p_db;
    logic [1:0]   d_cnt, f_cnt, p_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         ev;
        logic [123:0] eb;
        logic         dr;
        logic         fl;
        logic         x_er;
        logic         x_dv;
        logic [1:0]   x_cnt;
        logic         chk_b;
        logic [123:0] x_b;
    } vec_t;

    vec_t vq[$];

    queue_2x124 #(.FLOW(0), .PIPE(0)) u_dut (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(d_er), .io_enq_bits(enq_bits),
        .io_deq_valid(d_dv), .io_deq_ready(deq_ready), .io_deq_bits(d_db),
        .io_flush(flush), .io_count(d_cnt)
    );

    queue_2x124 #(.FLOW(1), .PIPE(0)) u_flow (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(f_er), .io_enq_bits(enq_bits),
        .io_deq_valid(f_dv), .io_deq_ready(deq_ready), .io_deq_bits(f_db),
        .io_flush(flush), .io_count(f_cnt)
    );

    queue_2x124 #(.FLOW(0), .PIPE(1)) u_pipe (
        .clock(clock), .reset(reset),
        .io_enq_valid(enq_valid), .io_enq_ready(p_er), .io_enq_bits(enq_bits),
        .io_deq_valid(p_dv), .io_deq_ready(deq_ready), .io_deq_bits(p_db),
        .io_flush(flush), .io_count(p_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [123:0] act,
                       input logic [123:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [123:0] eb,
                         input logic dr, input logic fl);
        @(negedge clock);
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic add(input logic ev, input logic [123:0] eb, input logic dr,
                       input logic fl, input logic xer, input logic xdv,
                       input logic [1:0] xc, input logic cb,
                       input logic [123:0] xb);
        vec_t v;
        v.ev = ev; v.eb = eb; v.dr = dr; v.fl = fl;
        v.x_er = xer; v.x_dv = xdv; v.x_cnt = xc;
        v.chk_b = cb; v.x_b = xb;
        vq.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        enq_valid = 1'b1;
        enq_bits = 124'h77;
        deq_ready = 1'b0;
        flush = 1'b0;

        // Vector table: inputs for one cycle, outputs expected before its edge.
        add(1, 124'h1, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'h2, 0, 0, 1, 1, 2'd1, 1, 124'h1);
        add(1, 124'h3, 0, 0, 0, 1, 2'd2, 1, 124'h1);
        add(0, 124'h0, 1, 0, 0, 1, 2'd2, 1, 124'h1);
        add(0, 124'h0, 1, 0, 1, 1, 2'd1, 1, 124'h2);
        add(0, 124'h0, 1, 0, 1, 0, 2'd0, 0, 124'h0);
        add(0, 124'h0, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'hA, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'hB, 0, 0, 1, 1, 2'd1, 1, 124'hA);
        add(1, 124'hC, 0, 1, 0, 1, 2'd2, 1, 124'hA);
        add(0, 124'h0, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'hD, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'hE, 1, 1, 1, 1, 2'd1, 1, 124'hD);
        add(0, 124'h0, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(1, 124'hF, 0, 0, 1, 0, 2'd0, 0, 124'h0);
        add(0, 124'h0, 0, 0, 1, 1, 2'd1, 1, 124'hF);

        // Outputs while reset is held.
        #2;
        chk("rst_enq_ready", {123'd0, d_er}, 124'd1);
        chk("rst_deq_valid", {123'd0, d_dv}, 124'd0);
        chk("rst_count", {122'd0, d_cnt}, 124'd0);
        chk("rst_flow_deq_valid", {123'd0, f_dv}, 124'd1);
        chk("rst_flow_count", {122'd0, f_cnt}, 124'd0);

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ev, vq[i].eb, vq[i].dr, vq[i].fl);
            chk($sformatf("v%0d_enq_ready", i), {123'd0, d_er}, {123'd0, vq[i].x_er});
            chk($sformatf("v%0d_deq_valid", i), {123'd0, d_dv}, {123'd0, vq[i].x_dv});
            chk($sformatf("v%0d_count", i), {122'd0, d_cnt}, {122'd0, vq[i].x_cnt});
            if (vq[i].chk_b)
                chk($sformatf("v%0d_deq_bits", i), d_db, vq[i].x_b);
        end

        // Streaming: one-cycle lag, count steady at 1, pointers wrap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 124'(i), 1, 0);
            chk($sformatf("s%0d_count", i), {122'd0, d_cnt}, (i == 0) ? 124'd0 : 124'd1);
            chk($sformatf("s%0d_deq_valid", i), {123'd0, d_dv}, (i == 0) ? 124'd0 : 124'd1);
            if (i > 0) chk($sformatf("s%0d_deq_bits", i), d_db, 124'(i - 1));
        end
        drive(0, 124'h0, 1, 0);
        chk("s_tail_bits", d_db, 124'd9);
        chk("s_tail_valid", {123'd0, d_dv}, 124'd1);
        drive(0, 124'h0, 1, 0);
        chk("s_end_valid", {123'd0, d_dv}, 124'd0);
        chk("s_end_count", {122'd0, d_cnt}, 124'd0);

        // Flow-through: same-cycle delivery, nothing stored.
        do_reset();
        drive(1, 124'hABC, 1, 0);
        chk("flow_deq_valid", {123'd0, f_dv}, 124'd1);
        chk("flow_deq_bits", f_db, 124'hABC);
        chk("flow_count0", {122'd0, f_cnt}, 124'd0);
        drive(0, 124'h0, 0, 0);
        chk("flow_after_count", {122'd0, f_cnt}, 124'd0);
        chk("flow_after_valid", {123'd0, f_dv}, 124'd0);
        drive(1, 124'h123, 0, 0);
        chk("flow_nr_bits", f_db, 124'h123);
        drive(0, 124'h0, 0, 0);
        chk("flow_nr_count", {122'd0, f_cnt}, 124'd1);
        chk("flow_nr_head", f_db, 124'h123);

        // Pipelined enqueue into a full queue while it drains.
        do_reset();
        drive(1, 124'h5, 0, 0);
        drive(1, 124'h6, 0, 0);
        drive(1, 124'h7, 1, 0);
        chk("pipe_enq_ready", {123'd0, p_er}, 124'd1);
        chk("pipe_deq_bits0", p_db, 124'h5);
        chk("pipe_count_full", {122'd0, p_cnt}, 124'd2);
        chk("base_full_ready", {123'd0, d_er}, 124'd0);
        drive(0, 124'h0, 1, 0);
        chk("pipe_count_hold", {122'd0, p_cnt}, 124'd2);
        chk("pipe_deq_bits1", p_db, 124'h6);
        drive(0, 124'h0, 1, 0);
        chk("pipe_deq_bits2", p_db, 124'h7);
        chk("pipe_count1", {122'd0, p_cnt}, 124'd1);
        drive(0, 124'h0, 0, 0);
        chk("pipe_empty_valid", {123'd0, p_dv}, 124'd0);

        // Asynchronous reset between edges.
        do_reset();
        drive(1, 124'h21, 0, 0);
        drive(1, 124'h22, 0, 0);
        drive(0, 124'h0, 0, 0);
        chk("pre_arst_count", {122'd0, d_cnt}, 124'd2);
        reset = 1'b1;
        #1;
        chk("arst_count", {122'd0, d_cnt}, 124'd0);
        chk("arst_enq_ready", {123'd0, d_er}, 124'd1);
        chk("arst_deq_valid", {123'd0, d_dv}, 124'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
